// File: rtl/range_gen.sv
// Candidate-word range generator: steps an odometer over per-range charsets,
// presenting one candidate per accepted output handshake.
module range_gen #(
  parameter int CHAR_BITS      = 7,
  parameter int WORD_MAX_LEN   = 8,
  parameter int RANGES_MAX     = 4,
  parameter int CHARS_MAX      = 16,
  parameter int RANGE_INFO_MSB = $clog2(WORD_MAX_LEN)
) (
  input  logic                                     CLK,
  input  logic                                     reset,
  input  logic                                     cfg_wr_en,
  input  logic [$clog2(RANGES_MAX)-1:0]            cfg_range_idx,
  input  logic [$clog2(CHARS_MAX)-1:0]             cfg_char_idx,
  input  logic [CHAR_BITS-1:0]                     cfg_char,
  input  logic                                     cfg_num_wr,
  input  logic [$clog2(CHARS_MAX+1)-1:0]           cfg_num_chars,
  input  logic                                     start,
  input  logic [WORD_MAX_LEN*CHAR_BITS-1:0]        word,
  input  logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0] range_info,
  output logic                                     busy,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_last,
  output logic [WORD_MAX_LEN*CHAR_BITS-1:0]        out_word,
  output logic [RANGES_MAX*CHAR_BITS-1:0]          out_ranges,
  output logic [WORD_MAX_LEN-1:0]                  out_if_range,
  output logic [WORD_MAX_LEN*RANGE_INFO_MSB-1:0]   out_shift_val
);

  localparam int CIW = $clog2(CHARS_MAX);
  localparam int NCW = $clog2(CHARS_MAX + 1);
  localparam int RW  = RANGE_INFO_MSB + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [CHAR_BITS-1:0]  r_table [RANGES_MAX][CHARS_MAX];
  logic [NCW-1:0]        r_num   [RANGES_MAX];
  logic [NCW-1:0]        r_cnt   [RANGES_MAX];
  logic [NCW-1:0]        w_cnt_nxt [RANGES_MAX];
  logic [NCW-1:0]        w_len   [RANGES_MAX];
  logic [RANGES_MAX-1:0] r_active;
  logic [RANGES_MAX-1:0] w_at_max;
  logic [WORD_MAX_LEN-1:0]                w_if_range;
  logic [WORD_MAX_LEN*RANGE_INFO_MSB-1:0] w_shift_val;
  logic w_accept;

  assign out_valid = (r_state == RUN);
  assign busy      = (r_state == RUN);
  assign w_accept  = out_valid && out_ready;
  assign out_last  = (r_state == RUN) && (&w_at_max);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_accept && out_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Position decode from the incoming range_info, captured on start.
  always_comb begin
    int unsigned pos;
    pos         = 0;
    w_if_range  = '0;
    w_shift_val = '0;
    for (int unsigned j = 0; j < RANGES_MAX; j++) begin
      if (range_info[j*RW + RW - 1]) begin
        pos = 32'(range_info[j*RW +: RANGE_INFO_MSB]) + j;
        if (pos < WORD_MAX_LEN) begin
          w_if_range[pos] = 1'b1;
          w_shift_val[pos*RANGE_INFO_MSB +: RANGE_INFO_MSB] =
            w_shift_val[pos*RANGE_INFO_MSB +: RANGE_INFO_MSB] |
            range_info[j*RW +: RANGE_INFO_MSB];
        end
      end
    end
  end

  // Odometer: inactive or zero-length ranges behave as length 1.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int unsigned j = 0; j < RANGES_MAX; j++) begin
      w_len[j]     = (!r_active[j] || r_num[j] == '0) ? NCW'(1) : r_num[j];
      w_at_max[j]  = (r_cnt[j] == w_len[j] - 1'b1);
      w_cnt_nxt[j] = r_cnt[j];
      if (carry) w_cnt_nxt[j] = w_at_max[j] ? '0 : r_cnt[j] + 1'b1;
      carry = carry & w_at_max[j];
    end
  end

  always_comb begin
    out_ranges = '0;
    for (int unsigned j = 0; j < RANGES_MAX; j++)
      if (r_active[j])
        out_ranges[j*CHAR_BITS +: CHAR_BITS] = r_table[j][r_cnt[j][CIW-1:0]];
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_active      <= '0;
      out_word      <= '0;
      out_if_range  <= '0;
      out_shift_val <= '0;
      for (int unsigned j = 0; j < RANGES_MAX; j++) begin
        r_num[j] <= '0;
        r_cnt[j] <= '0;
        for (int unsigned k = 0; k < CHARS_MAX; k++) r_table[j][k] <= '0;
      end
    end else if (r_state == IDLE) begin
      if (cfg_wr_en)  r_table[cfg_range_idx][cfg_char_idx] <= cfg_char;
      if (cfg_num_wr) r_num[cfg_range_idx] <= cfg_num_chars;
      if (start) begin
        out_word      <= word;
        out_if_range  <= w_if_range;
        out_shift_val <= w_shift_val;
        for (int unsigned j = 0; j < RANGES_MAX; j++) begin
          r_active[j] <= range_info[j*RW + RW - 1];
          r_cnt[j]    <= '0;
        end
      end
    end else if (w_accept) begin
      for (int unsigned j = 0; j < RANGES_MAX; j++) r_cnt[j] <= w_cnt_nxt[j];
    end
  end

endmodule
